// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences one instruction at a time through FETCH / DECODE and then one of
// the execution paths (ALU, load, store, branch, jump). Unknown opcodes and
// unsupported R-type functs park the FSM in TRAP until reset.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   op, funct           instruction[31:26] / instruction[5:0] from the IR
//   zero                ALU zero flag (used by beq/bne)
//   mem_ack             one-cycle memory completion strobe
//   mem_req, mem_we     memory request and its write qualifier
//   iord                memory address select (0=PC, 1=ALUOut)
//   ir_we, pc_we        instruction register / PC load enables
//   pc_src              PC source (00=ALU C, 01=ALUOut, 10=jump target)
//   rf_we, reg_dst      register file write enable and destination select
//   wd_sel              register write data select (00=ALUOut, 01=MDR, 10=PC)
//   alusrca, alusrcb    ALU operand selects
//   aluop               ALU operation code
//   illegal             trap flag
//   instret             retired-instruction counter
//
// Handshake: mem_req stays high in a memory state until the cycle mem_ack is
// seen high; that cycle completes the access and the FSM advances on the
// following edge. mem_ack in any other state has no effect.
//
// op and funct are read live from the instruction register, which is only
// reloaded in FETCH, so they remain valid from DECODE to the end of the
// instruction.
module mc_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [1:0]  alusrca,
  output logic [2:0]  alusrcb,
  output logic [3:0]  aluop,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_ADDU = 4'b1001;
  localparam logic [3:0] ALU_SUBU = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state, next_state;

  // R-type funct decode.
  logic       r_legal;
  logic [3:0] r_aluop;
  logic [1:0] r_srca;

  always_comb begin
    r_legal = 1'b1;
    r_aluop = ALU_NOP;
    r_srca  = 2'b01;
    case (funct)
      6'b100000: r_aluop = ALU_ADD;
      6'b100001: r_aluop = ALU_ADDU;
      6'b100010: r_aluop = ALU_SUB;
      6'b100011: r_aluop = ALU_SUBU;
      6'b100100: r_aluop = ALU_AND;
      6'b100101: r_aluop = ALU_OR;
      6'b100111: r_aluop = ALU_NOR;
      6'b101010: r_aluop = ALU_SLT;
      6'b101011: r_aluop = ALU_SLTU;
      // Constant shifts take the amount from shamt, variable shifts from rs.
      6'b000000: begin r_aluop = ALU_SLL; r_srca = 2'b10; end
      6'b000010: begin r_aluop = ALU_SRL; r_srca = 2'b10; end
      6'b000100: r_aluop = ALU_SLL;
      6'b000110: r_aluop = ALU_SRL;
      default:   r_legal = 1'b0;
    endcase
  end

  // I-type opcode decode (EXEC path only).
  logic       i_legal;
  logic [3:0] i_aluop;
  logic [2:0] i_srcb;

  always_comb begin
    i_legal = 1'b1;
    i_aluop = ALU_NOP;
    i_srcb  = 3'b010;
    case (op)
      OP_ADDI:  i_aluop = ALU_ADD;
      OP_ADDIU: i_aluop = ALU_ADDU;
      OP_SLTI:  i_aluop = ALU_SLT;
      OP_ANDI:  begin i_aluop = ALU_AND; i_srcb = 3'b011; end
      OP_ORI:   begin i_aluop = ALU_OR;  i_srcb = 3'b011; end
      OP_LUI:   begin i_aluop = ALU_LUI; i_srcb = 3'b011; end
      default:  i_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    rf_we      = 1'b0;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 3'b000;
    aluop      = ALU_NOP;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 3'b001;
        aluop   = ALU_ADD;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrcb = 3'b100;
        aluop   = ALU_ADD;
        if (op == OP_RTYPE)                 next_state = r_legal ? S_EXEC : S_TRAP;
        else if (i_legal)                   next_state = S_EXEC;
        else if (op == OP_LW || op == OP_SW) next_state = S_MEMADR;
        else if (op == OP_BEQ || op == OP_BNE) next_state = S_BRANCH;
        else if (op == OP_J || op == OP_JAL)   next_state = S_JUMP;
        else                                next_state = S_TRAP;
      end
      S_EXEC: begin
        next_state = S_ALUWB;
        alusrca    = (op == OP_RTYPE) ? r_srca : 2'b01;
        alusrcb    = (op == OP_RTYPE) ? 3'b000 : i_srcb;
        aluop      = (op == OP_RTYPE) ? r_aluop : i_aluop;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        reg_dst    = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        next_state = S_FETCH;
      end
      S_MEMADR: begin
        alusrca    = 2'b01;
        alusrcb    = 3'b010;
        aluop      = ALU_ADD;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        wd_sel     = 2'b01;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack) next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 2'b01;
        aluop      = ALU_SUB;
        pc_src     = 2'b01;
        pc_we      = (op == OP_BNE) ? ~zero : zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'b10;
        if (op == OP_JAL) begin
          rf_we   = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end
        next_state = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset must silence the outputs immediately, not at the next edge, so a
    // pending memory request is withdrawn in the same cycle rstn falls.
    if (!rstn) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      iord    = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 2'b00;
      rf_we   = 1'b0;
      reg_dst = 2'b00;
      wd_sel  = 2'b00;
      alusrca = 2'b00;
      alusrcb = 3'b000;
      aluop   = ALU_NOP;
      illegal = 1'b0;
    end
  end

  // An instruction retires when its final state hands back to FETCH.
  logic retire;
  assign retire = (next_state == S_FETCH) &&
                  (state == S_ALUWB || state == S_MEMWB || state == S_MEMWR ||
                   state == S_BRANCH || state == S_JUMP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end

endmodule
